muladd_stream_mac: RTL and testbench
====================================

// Module: muladd_stream_mac
// PURPOSE
//  Parametrised streaming dot-product engine for the MulAdd accelerator data path.
//  - Accepts packed operand beats of LANES signed elements on the load stream.
//  - Buffers one input row (A), then streams NUM_OUT weight columns against it.
//  - Per column: multiply-accumulate, emit one scaled, saturated result on a ready/valid port.
//  - Generalises the fixed 2x16-bit / 16-element / 8-column loader with backpressure and parametrised sizing.
// PARAMETERS
//  DATA_W     16  signed operand element width
//  LANES       2  elements per load beat; VEC_LEN % LANES == 0 required
//  VEC_LEN    16  elements per row/column; BEATS = VEC_LEN/LANES
//  NUM_OUT     8  weight columns per input row
//  ACC_W      40  signed accumulator width (>= 2*DATA_W + clog2(VEC_LEN))
//  FRAC_BITS   8  arithmetic right shift applied to final accumulator
//  OUT_W      16  signed result width
// PORTS
//  clk_data          in   1              single clock, rising edge
//  rst               in   1              synchronous, active-high reset
//  load_en_i         in   1              load beat valid
//  load_payload_i    in   LANES*DATA_W   lane l = bits [l*DATA_W +: DATA_W]; element = beat*LANES + l
//  load_ready_o      out  1              beat accepted when load_en_i && load_ready_o
//  result_valid_o    out  1              result register holds an unconsumed result
//  result_payload_o  out  OUT_W          signed scaled dot product
//  result_ready_i    in   1              consumer accepts result when valid && ready
//  done_o            out  1              1-cycle pulse after the NUM_OUT-th result is produced
// BEHAVIOUR
//  Reset values
//  - rst=1 at a clock edge returns state to S_LOAD_A and clears beat_cnt, col_cnt and acc.
//  - result_valid_o=0, result_payload_o=0, done_o=0, load_ready_o=1 from the following cycle.
//  - A buffer is not reset; its contents are don't-care.
//  States
//  - S_LOAD_A: each accepted beat writes LANES elements into A[beat_cnt*LANES +: LANES].
//    After BEATS beats -> S_LOAD_W, col_cnt=0, beat_cnt=0.
//  - S_LOAD_W: each accepted beat computes acc_next = acc + sum_l A[beat_cnt*LANES+l]*W_l.
//    - Full signed DATA_W x DATA_W products, sign-extended to ACC_W; wrap on ACC_W overflow.
//  - Last beat of a column (beat_cnt == BEATS-1):
//    - Result register <= sat_OUT_W(acc_next >>> FRAC_BITS); result_valid_o=1 next cycle.
//    - acc cleared; col_cnt increments.
//    - If col_cnt == NUM_OUT-1: done_o pulses next cycle and state -> S_LOAD_A.
//  Latency
//  - result_valid_o rises 1 cycle after the column's last beat is accepted.
//  - No pipeline bubbles: back-to-back beats accepted every cycle.
//  Saturation
//  - Shifted value > 2^(OUT_W-1)-1 gives 0x7FFF (defaults).
//  - Shifted value < -2^(OUT_W-1) gives 0x8000 (defaults).
//  Backpressure
//  - load_ready_o=0 only when state==S_LOAD_W, beat_cnt==BEATS-1, result_valid_o=1 and result_ready_i=0.
//  - Non-final beats are never stalled.
//  Simultaneous consume and produce
//  - Result consumed and new result produced in the same cycle: register is overwritten and valid stays 1.
//  - No result is ever lost or duplicated.
//  Other boundary conditions
//  - load_en_i=0 holds all counters; gaps of any length are allowed mid-row or mid-column.
//  - A result pending at the end of a row remains valid during the next S_LOAD_A and is not cleared.
//  - Mid-operation reset discards partial acc and any pending result; the next accepted beat is A element 0.
// TESTING
//  1. Hold rst 3 cycles, then deassert -> result_valid_o=0, done_o=0, load_ready_o=1, result_payload_o=0.
//  2. A = 16 x 0x0100, one column W = 16 x 0x0100, result_ready_i=1 -> result 0x1000, valid 1 cycle after beat 16.
//  3. A = 16 x 0x7FFF with W = 16 x 0x7FFF -> 0x7FFF; same A with W = 16 x 0x8000 -> 0x8000.
//  4. result_ready_i=0 after col 0, col 1 streamed -> load_ready_o=0 on col 1 last beat until ready; col 0 then col 1 results intact.
//  5. Random A plus 8 random columns, random load_en_i gaps -> 8 results match golden model in order; done_o one pulse after 8th; next beat loads A.
//  6. Assert rst at beat 5 of col 3 -> no col 3 result, result_valid_o=0; new A + 8 cols produce correct results.

Source files
------------

// File: rtl/muladd_stream_mac_if.sv
// Load-stream and result-stream handshake bundle for the MulAdd dot-product engine.
// The slave modport is the engine's view; the master modport is the producer/consumer view.
interface muladd_stream_mac_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int OUT_W  = 16
);
  logic                      load_en_i;
  logic [LANES*DATA_W-1:0]   load_payload_i;
  logic                      load_ready_o;
  logic                      result_valid_o;
  logic [OUT_W-1:0]          result_payload_o;
  logic                      result_ready_i;
  logic                      done_o;

  modport slave (
    input  load_en_i, load_payload_i, result_ready_i,
    output load_ready_o, result_valid_o, result_payload_o, done_o
  );

  modport master (
    output load_en_i, load_payload_i, result_ready_i,
    input  load_ready_o, result_valid_o, result_payload_o, done_o
  );
endinterface

// File: rtl/muladd_stream_mac.sv
// Streaming dot-product engine: buffers one row A, then multiply-accumulates NUM_OUT
// weight columns against it, emitting one scaled, saturated result per column.
module muladd_stream_mac #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 2,
  parameter int VEC_LEN   = 16,
  parameter int NUM_OUT   = 8,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16
) (
  input  logic               clk_data,
  input  logic               rst,
  muladd_stream_mac_if.slave bus
);
  localparam int BEATS  = VEC_LEN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int COL_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {S_LOAD_A, S_LOAD_W} state_t;

  state_t                    r_state, w_state_next;
  logic [BEAT_W-1:0]         r_beat_cnt, w_beat_cnt_next;
  logic [COL_W-1:0]          r_col_cnt, w_col_cnt_next;
  logic signed [ACC_W-1:0]   r_acc, w_sum, w_acc_next, w_shifted;
  logic signed [DATA_W-1:0]  r_a [VEC_LEN];
  logic                      r_res_valid, r_done;
  logic [OUT_W-1:0]          r_res, w_sat;
  logic                      w_last_beat, w_load_ready, w_accept, w_produce, w_row_done, w_ovf;
  logic signed [DATA_W-1:0]  w_lane [LANES];
  logic signed [PROD_W-1:0]  w_prod [LANES];
  logic [IDX_W-1:0]          w_idx  [LANES];

  assign w_last_beat  = (r_beat_cnt == BEAT_W'(BEATS - 1));
  // Only the column-closing beat needs a free result slot; a consume in the same cycle frees it.
  assign w_load_ready = !((r_state == S_LOAD_W) && w_last_beat && r_res_valid && !bus.result_ready_i);
  assign w_accept     = bus.load_en_i && w_load_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = bus.load_payload_i[gi*DATA_W +: DATA_W];
      assign w_idx[gi]  = IDX_W'(r_beat_cnt) * IDX_W'(LANES) + IDX_W'(gi);
      assign w_prod[gi] = PROD_W'(r_a[w_idx[gi]]) * PROD_W'(w_lane[gi]);
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = w_sum + ACC_W'(w_prod[l]);
    end
  end

  assign w_acc_next = r_acc + w_sum;
  assign w_shifted  = w_acc_next >>> FRAC_BITS;
  // Fits in OUT_W only if every bit above the result sign bit matches it.
  assign w_ovf = !((&w_shifted[ACC_W-1:OUT_W-1]) || !(|w_shifted[ACC_W-1:OUT_W-1]));
  assign w_sat = !w_ovf ? w_shifted[OUT_W-1:0]
               : (w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_col_cnt_next  = r_col_cnt;
    w_produce       = 1'b0;
    w_row_done      = 1'b0;
    if (w_accept) begin
      if (w_last_beat) begin
        w_beat_cnt_next = '0;
        if (r_state == S_LOAD_A) begin
          w_state_next   = S_LOAD_W;
          w_col_cnt_next = '0;
        end else begin
          w_produce = 1'b1;
          if (r_col_cnt == COL_W'(NUM_OUT - 1)) begin
            w_row_done     = 1'b1;
            w_state_next   = S_LOAD_A;
            w_col_cnt_next = '0;
          end else begin
            w_col_cnt_next = r_col_cnt + 1'b1;
          end
        end
      end else begin
        w_beat_cnt_next = r_beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_state    <= S_LOAD_A;
      r_beat_cnt <= '0;
      r_col_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_col_cnt  <= w_col_cnt_next;
    end
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_acc       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_row_done;
      if (w_accept && r_state == S_LOAD_W) begin
        r_acc <= w_last_beat ? '0 : w_acc_next;
      end
      if (w_produce) begin
        r_res       <= w_sat;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && bus.result_ready_i) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Row buffer carries no reset; it is always fully rewritten before use.
  always_ff @(posedge clk_data) begin
    if (w_accept && r_state == S_LOAD_A) begin
      for (int l = 0; l < LANES; l++) begin
        r_a[w_idx[l]] <= w_lane[l];
      end
    end
  end

  assign bus.load_ready_o     = w_load_ready;
  assign bus.result_valid_o   = r_res_valid;
  assign bus.result_payload_o = r_res;
  assign bus.done_o           = r_done;
endmodule

// File: tb/tb_muladd_stream_mac.sv
// Directed bench for muladd_stream_mac: fixed rows/columns with hand-computed results,
// plus pseudo-random rows checked against a small reference dot product.
module tb_muladd_stream_mac;
  localparam int DATA_W = 16;
  localparam int LANES  = 2;
  localparam int OUT_W  = 16;

  typedef logic [15:0] vec_t [16];

  logic clk_data = 1'b0;
  logic rst      = 1'b1;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  logic [15:0] got_q [$];

  always #5 clk_data = ~clk_data;

  muladd_stream_mac_if #(.DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();

  muladd_stream_mac #(
    .DATA_W(16), .LANES(2), .VEC_LEN(16), .NUM_OUT(8),
    .ACC_W(40), .FRAC_BITS(8), .OUT_W(16)
  ) dut (
    .clk_data (clk_data),
    .rst      (rst),
    .bus      (bus.slave)
  );

  // Records every consumed result and every done pulse, sampled mid-cycle.
  always @(negedge clk_data) begin
    if (!rst) begin
      if (bus.result_valid_o && bus.result_ready_i) got_q.push_back(bus.result_payload_o);
      if (bus.done_o) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_data);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] pl);
    int   n = 0;
    logic ok;
    bus.load_en_i      = 1'b1;
    bus.load_payload_i = pl;
    do begin
      ok = bus.load_ready_o;
      step();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("beat_accept_timeout", 32'(ok), 32'd1);
    bus.load_en_i = 1'b0;
  endtask

  task automatic send_row(input vec_t v, input bit gaps);
    for (int b = 0; b < 8; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_beat({v[2*b+1], v[2*b]});
    end
  endtask

  function automatic vec_t const_vec(input logic [15:0] x);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t rand_vec(input bit full);
    vec_t v;
    int   t;
    for (int i = 0; i < 16; i++) begin
      t    = full ? int'($urandom) : int'($urandom_range(0, 1023)) - 512;
      v[i] = t[15:0];
    end
    return v;
  endfunction

  function automatic logic [15:0] ref_dot(input vec_t a, input vec_t w);
    longint s = 0;
    for (int i = 0; i < 16; i++) s += longint'($signed(a[i])) * longint'($signed(w[i]));
    s = s >>> 8;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One full random row of 8 columns with idle gaps, checked in order against ref_dot.
  task automatic random_row(input string tag);
    vec_t        a, w;
    logic [15:0] exp_q [$];
    int          d0;
    d0 = done_cnt;
    got_q.delete();
    a = rand_vec(1'b0);
    send_row(a, 1'b1);
    for (int c = 0; c < 8; c++) begin
      w = rand_vec(c == 2 || c == 5);
      exp_q.push_back(ref_dot(a, w));
      send_row(w, 1'b1);
    end
    check({tag, "_done_pulse"}, 32'(bus.done_o), 32'd1);
    check({tag, "_last_valid"}, 32'(bus.result_valid_o), 32'd1);
    step();
    check({tag, "_done_low"}, 32'(bus.done_o), 32'd0);
    step();
    check({tag, "_count"}, 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("%s_res%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    bus.load_en_i      = 1'b0;
    bus.load_payload_i = '0;
    bus.result_ready_i = 1'b1;

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", 32'(bus.result_valid_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_ready", 32'(bus.load_ready_o), 32'd1);
    check("rst_payload", 32'(bus.result_payload_o), 32'h0);

    // Basic column: 16 * 0x100*0x100 >>> 8 = 0x1000, valid one cycle after last beat
    send_row(const_vec(16'h0100), 1'b0);
    for (int b = 0; b < 7; b++) send_beat({16'h0100, 16'h0100});
    check("basic_valid_early", 32'(bus.result_valid_o), 32'd0);
    send_beat({16'h0100, 16'h0100});
    check("basic_valid", 32'(bus.result_valid_o), 32'd1);
    check("basic_payload", 32'(bus.result_payload_o), 32'h1000);
    step();
    check("basic_consumed", 32'(bus.result_valid_o), 32'd0);

    // Saturation both ways
    do_reset();
    send_row(const_vec(16'h7FFF), 1'b0);
    send_row(const_vec(16'h7FFF), 1'b0);
    check("sat_pos", 32'(bus.result_payload_o), 32'h7FFF);
    send_row(const_vec(16'h8000), 1'b0);
    check("sat_neg", 32'(bus.result_payload_o), 32'h8000);
    check("sat_neg_valid", 32'(bus.result_valid_o), 32'd1);

    // Backpressure on column-closing beat
    do_reset();
    got_q.delete();
    bus.result_ready_i = 1'b0;
    send_row(const_vec(16'h0100), 1'b0);
    send_row(const_vec(16'h0100), 1'b0);
    check("bp_col0", 32'(bus.result_payload_o), 32'h1000);
    for (int b = 0; b < 7; b++) begin
      check($sformatf("bp_nonfinal_ready%0d", b), 32'(bus.load_ready_o), 32'd1);
      send_beat({16'h0200, 16'h0200});
    end
    bus.load_en_i      = 1'b1;
    bus.load_payload_i = {16'h0200, 16'h0200};
    for (int k = 0; k < 3; k++) begin
      check("bp_stalled", 32'(bus.load_ready_o), 32'd0);
      check("bp_hold", 32'(bus.result_payload_o), 32'h1000);
      step();
    end
    bus.result_ready_i = 1'b1;
    #1;
    check("bp_released", 32'(bus.load_ready_o), 32'd1);
    @(posedge clk_data);
    #1;
    bus.load_en_i = 1'b0;
    check("bp_overwrite_valid", 32'(bus.result_valid_o), 32'd1);
    check("bp_col1", 32'(bus.result_payload_o), 32'h2000);
    step();
    check("bp_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("bp_q0", 32'(got_q[0]), 32'h1000);
      check("bp_q1", 32'(got_q[1]), 32'h2000);
    end

    // Random row with gaps, then confirm the engine is back to loading A
    do_reset();
    random_row("rand1");
    got_q.delete();
    send_row(const_vec(16'h0100), 1'b0);
    send_row(const_vec(16'h0100), 1'b0);
    check("reload_payload", 32'(bus.result_payload_o), 32'h1000);

    // Mid-column reset with a result pending: 256*128*16 >>> 8 = 0x0800 for col 1
    send_row(const_vec(16'h0080), 1'b0);
    step();
    bus.result_ready_i = 1'b0;
    send_row(const_vec(16'h0300), 1'b0);
    for (int b = 0; b < 5; b++) send_beat({16'h0100, 16'h0100});
    bus.load_en_i      = 1'b1;
    bus.load_payload_i = {16'h0100, 16'h0100};
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.load_en_i      = 1'b0;
    bus.result_ready_i = 1'b1;
    check("midrst_valid", 32'(bus.result_valid_o), 32'd0);
    check("midrst_payload", 32'(bus.result_payload_o), 32'h0);
    repeat (3) step();
    check("midrst_no_col3", 32'(bus.result_valid_o), 32'd0);
    check("midrst_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) check("midrst_col1", 32'(got_q[1]), 32'h0800);
    random_row("rand2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
